// File: rtl/gearbox_unpack.sv
// Splits each IN_WIDTH FIFO word into NUM_BEATS OUT_WIDTH beats on a valid/ready stream.
// Optional: GBX_UNPACK_MSB_FIRST_EN sends the most significant slice first.
module gearbox_unpack #(
  parameter int IN_WIDTH    = 64,
  parameter int OUT_WIDTH   = 16,
  parameter int FIFO_RD_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 fifo_empty_in,
  output logic                 fifo_pop_out,
  input  logic [IN_WIDTH-1:0]  fifo_data_in,
  output logic                 out_valid_out,
  input  logic                 out_ready_in,
  output logic [OUT_WIDTH-1:0] out_data_out,
  output logic                 out_last_out,
  output logic                 busy_out
);

  localparam int NUM_BEATS = IN_WIDTH / OUT_WIDTH;
  localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [IN_WIDTH-1:0] word_ff, word_nx;
  logic [BW-1:0]       beat_ff, beat_nx;
  logic [BW-1:0]       slice_idx;
  logic                pop_req;
  logic                xfer;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      word_ff <= '0;
      beat_ff <= '0;
    end else begin
      state   <= state_nx;
      word_ff <= word_nx;
      beat_ff <= beat_nx;
    end
  end

  assign out_valid_out = (state == SHIFT);
  assign xfer          = out_valid_out & out_ready_in;
  assign busy_out      = (state != IDLE);
  assign out_last_out  = (beat_ff == LAST_BEAT) & out_valid_out;
  // Pop is combinational, so it is masked while reset holds the FSM in IDLE
  assign fifo_pop_out  = pop_req & rstn;

  always_comb begin
    state_nx = state;
    word_nx  = word_ff;
    beat_nx  = beat_ff;
    pop_req  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty_in) begin
          pop_req = 1'b1;
          if (FIFO_RD_LAT == 0) begin
            word_nx  = fifo_data_in;
            beat_nx  = '0;
            state_nx = SHIFT;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        word_nx  = fifo_data_in;
        beat_nx  = '0;
        state_nx = SHIFT;
      end
      SHIFT: begin
        if (xfer) begin
          if (beat_ff == LAST_BEAT) begin
            beat_nx = '0;
            if (!fifo_empty_in) begin
              pop_req = 1'b1;
              if (FIFO_RD_LAT == 0) begin
                word_nx = fifo_data_in;
              end else begin
                state_nx = WAIT;
              end
            end else begin
              state_nx = IDLE;
            end
          end else begin
            beat_nx = beat_ff + BW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef GBX_UNPACK_MSB_FIRST_EN
  assign slice_idx = LAST_BEAT - beat_ff;
`else
  assign slice_idx = beat_ff;
`endif

  always_comb begin
    out_data_out = '0;
    for (int i = 0; i < NUM_BEATS; i++) begin
      if (slice_idx == BW'(i)) out_data_out = word_ff[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

endmodule
